// File: rtl/btn_event_if.sv
// Event channel between the button scheduler and its consumer.
// The producer drives valid/btn/type and the consumer drives ready.
interface btn_event_if #(
    parameter int N_BTN = 4
);
    localparam int BTN_W = (N_BTN > 1) ? $clog2(N_BTN) : 1;

    logic             event_valid;
    logic             event_ready;
    logic [BTN_W-1:0] event_btn;
    logic [1:0]       event_type;

    modport master (output event_valid, output event_btn, output event_type, input event_ready);
    modport slave  (input event_valid, input event_btn, input event_type, output event_ready);
endinterface

// File: rtl/btn_event_scheduler.sv
// Debounces N_BTN raw buttons on one shared sample tick, runs a press/hold/release
// FSM per button and serialises the resulting events round-robin onto one channel.
module btn_event_scheduler #(
    parameter int N_BTN        = 4,
    parameter int CLK_DIV      = 100000,
    parameter int STABLE_CNT   = 8,
    parameter int HOLD_TICKS   = 500,
    parameter int REPEAT_TICKS = 100
) (
    input  logic             clock1,
    input  logic             reset,
    input  logic [N_BTN-1:0] buttons,
    output logic [N_BTN-1:0] btn_level,
    output logic             overflow,
    btn_event_if.master      ev
);
    localparam int BTN_W    = (N_BTN > 1) ? $clog2(N_BTN) : 1;
    localparam int TICK_W   = $clog2(CLK_DIV);
    localparam int CNT_W    = $clog2(STABLE_CNT + 1);
    localparam int HCNT_MAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
    localparam int HCNT_W   = $clog2(HCNT_MAX + 1);

    localparam int EV_PRESS   = 0;
    localparam int EV_LONG    = 1;
    localparam int EV_REPEAT  = 2;
    localparam int EV_RELEASE = 3;

    typedef enum logic [2:0] {
        S_IDLE, S_ARMING, S_PRESSED, S_HELD, S_RELEASING
    } state_e;

    logic [N_BTN-1:0]   meta_q, sync_q;
    logic [TICK_W-1:0]  tick_q;
    logic               tick;

    state_e             state_q [N_BTN];
    state_e             state_d [N_BTN];
    logic [CNT_W-1:0]   cnt_q   [N_BTN];
    logic [CNT_W-1:0]   cnt_d   [N_BTN];
    logic [HCNT_W-1:0]  hcnt_q  [N_BTN];
    logic [HCNT_W-1:0]  hcnt_d  [N_BTN];
    logic [N_BTN-1:0]   origin_q, origin_d;   // 1 = RELEASING was entered from HELD

    logic [4*N_BTN-1:0] pend_q, pend_d, ev_set, clr, avail;
    logic               ovf_q, ovf_d;
    logic               valid_q, valid_d;
    logic [BTN_W-1:0]   btn_q, btn_d, ptr_q, ptr_d, ptr_eff;
    logic [1:0]         type_q, type_d;
    logic               grant;

    assign tick = (tick_q == TICK_W'(CLK_DIV - 1));

    // Per-button debounce FSM.
    // NOTE: every signal driven here gets a default before any branch, so no latch is inferred.
    always_comb begin
        ev_set   = '0;
        origin_d = origin_q;
        for (int b = 0; b < N_BTN; b++) begin
            state_d[b] = state_q[b];
            cnt_d[b]   = cnt_q[b];
            hcnt_d[b]  = hcnt_q[b];
            if (tick) begin
                unique case (state_q[b])
                    S_IDLE: if (sync_q[b]) begin
                        if (STABLE_CNT == 1) begin
                            state_d[b] = S_PRESSED;
                            hcnt_d[b]  = '0;
                            ev_set[b*4 + EV_PRESS] = 1'b1;
                        end else begin
                            state_d[b] = S_ARMING;
                            cnt_d[b]   = CNT_W'(1);
                        end
                    end
                    S_ARMING: begin
                        if (!sync_q[b]) begin
                            state_d[b] = S_IDLE;
                            cnt_d[b]   = '0;
                        end else if (cnt_q[b] + CNT_W'(1) == CNT_W'(STABLE_CNT)) begin
                            state_d[b] = S_PRESSED;
                            cnt_d[b]   = '0;
                            hcnt_d[b]  = '0;
                            ev_set[b*4 + EV_PRESS] = 1'b1;
                        end else begin
                            cnt_d[b] = cnt_q[b] + CNT_W'(1);
                        end
                    end
                    S_PRESSED, S_HELD: begin
                        if (!sync_q[b]) begin
                            origin_d[b] = (state_q[b] == S_HELD);
                            hcnt_d[b]   = '0;
                            if (STABLE_CNT == 1) begin
                                state_d[b] = S_IDLE;
                                ev_set[b*4 + EV_RELEASE] = 1'b1;
                            end else begin
                                state_d[b] = S_RELEASING;
                                cnt_d[b]   = CNT_W'(1);
                            end
                        end else if (state_q[b] == S_PRESSED) begin
                            if (hcnt_q[b] + HCNT_W'(1) == HCNT_W'(HOLD_TICKS)) begin
                                state_d[b] = S_HELD;
                                hcnt_d[b]  = '0;
                                ev_set[b*4 + EV_LONG] = 1'b1;
                            end else begin
                                hcnt_d[b] = hcnt_q[b] + HCNT_W'(1);
                            end
                        end else if (hcnt_q[b] + HCNT_W'(1) == HCNT_W'(REPEAT_TICKS)) begin
                            hcnt_d[b] = '0;
                            ev_set[b*4 + EV_REPEAT] = 1'b1;
                        end else begin
                            hcnt_d[b] = hcnt_q[b] + HCNT_W'(1);
                        end
                    end
                    S_RELEASING: begin
                        if (sync_q[b]) begin
                            state_d[b] = origin_q[b] ? S_HELD : S_PRESSED;
                            cnt_d[b]   = '0;
                            hcnt_d[b]  = '0;
                        end else if (cnt_q[b] + CNT_W'(1) == CNT_W'(STABLE_CNT)) begin
                            state_d[b] = S_IDLE;
                            cnt_d[b]   = '0;
                            ev_set[b*4 + EV_RELEASE] = 1'b1;
                        end else begin
                            cnt_d[b] = cnt_q[b] + CNT_W'(1);
                        end
                    end
                    default: state_d[b] = S_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        for (int b = 0; b < N_BTN; b++) begin
            btn_level[b] = (state_q[b] == S_PRESSED) || (state_q[b] == S_HELD) ||
                           (state_q[b] == S_RELEASING);
        end
    end

    // Pending bits and the registered round-robin output stage.
    always_comb begin
        int idx;
        logic found;
        grant = valid_q && ev.event_ready;
        clr   = '0;
        if (grant) clr[int'(btn_q)*4 + int'(type_q)] = 1'b1;

        // A set in the same cycle as its grant-clear wins and is not an overflow.
        pend_d = (pend_q & ~clr) | ev_set;
        ovf_d  = ovf_q | (|(ev_set & pend_q & ~clr));
        avail  = pend_q & ~clr;

        if (grant) ptr_eff = (int'(btn_q) == N_BTN - 1) ? '0 : btn_q + BTN_W'(1);
        else       ptr_eff = ptr_q;
        ptr_d = ptr_eff;

        valid_d = valid_q;
        btn_d   = btn_q;
        type_d  = type_q;
        found   = 1'b0;
        idx     = 0;
        if (!valid_q || grant) begin
            valid_d = 1'b0;
            for (int i = 0; i < N_BTN; i++) begin
                idx = int'(ptr_eff) + i;
                if (idx >= N_BTN) idx = idx - N_BTN;
                if (!found && (|avail[idx*4 +: 4])) begin
                    found   = 1'b1;
                    valid_d = 1'b1;
                    btn_d   = BTN_W'(idx);
                    if      (avail[idx*4 + EV_PRESS])  type_d = 2'(EV_PRESS);
                    else if (avail[idx*4 + EV_LONG])   type_d = 2'(EV_LONG);
                    else if (avail[idx*4 + EV_REPEAT]) type_d = 2'(EV_REPEAT);
                    else                               type_d = 2'(EV_RELEASE);
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock1 or posedge reset) begin
        if (reset) begin
            meta_q   <= '0;
            sync_q   <= '0;
            tick_q   <= '0;
            origin_q <= '0;
            pend_q   <= '0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
            btn_q    <= '0;
            type_q   <= '0;
            ptr_q    <= '0;
            for (int b = 0; b < N_BTN; b++) begin
                state_q[b] <= S_IDLE;
                cnt_q[b]   <= '0;
                hcnt_q[b]  <= '0;
            end
        end else begin
            // Two-flop synchroniser: the FSMs only ever look at sync_q.
            meta_q   <= buttons;
            sync_q   <= meta_q;
            tick_q   <= tick ? '0 : tick_q + TICK_W'(1);
            origin_q <= origin_d;
            pend_q   <= pend_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
            btn_q    <= btn_d;
            type_q   <= type_d;
            ptr_q    <= ptr_d;
            for (int b = 0; b < N_BTN; b++) begin
                state_q[b] <= state_d[b];
                cnt_q[b]   <= cnt_d[b];
                hcnt_q[b]  <= hcnt_d[b];
            end
        end
    end

    assign overflow       = ovf_q;
    assign ev.event_valid = valid_q;
    assign ev.event_btn   = btn_q;
    assign ev.event_type  = type_q;
endmodule
